// File: rtl/mysystem_nios2_mult_unit.sv
// Pipelined multiplier with valid/ready handshake, PIPE_STAGES deep.
// Define MYSYSTEM_NIOS2_MULT_HIGH_EN to build the high-half (MULX*) datapath.
module mysystem_nios2_mult_unit #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int L = PIPE_STAGES - 1;

`ifdef MYSYSTEM_NIOS2_MULT_HIGH_EN
  localparam int PW = 2 * DATA_W;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
`else
  localparam int PW = DATA_W;
`endif

  logic          advance;
  logic [PW-1:0] prod_in;

  logic          vld_q  [PIPE_STAGES];
  logic [1:0]    op_q   [PIPE_STAGES];
  logic [PW-1:0] prod_q [PIPE_STAGES];

  assign out_valid = vld_q[L];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

`ifdef MYSYSTEM_NIOS2_MULT_HIGH_EN
  logic              a_sgn;
  logic              b_sgn;
  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;

  // Sign-extend operands per op, then take the full-width product
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      (in_op == OP_MULXSS): begin
        a_sgn = in_src1[DATA_W-1];
        b_sgn = in_src2[DATA_W-1];
      end
      (in_op == OP_MULXSU): begin
        a_sgn = in_src1[DATA_W-1];
      end
      default: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
    endcase
    a_x     = {{DATA_W{a_sgn}}, in_src1};
    b_x     = {{DATA_W{b_sgn}}, in_src2};
    prod_in = a_x * b_x;
  end

  // Pick the product half requested by the op riding with the result
  always_comb begin
    out_result = prod_q[L][DATA_W-1:0];
    if (op_q[L] != OP_MUL)
      out_result = prod_q[L][PW-1:DATA_W];
  end
`else
  logic unused_op;

  assign prod_in    = in_src1 * in_src2;
  assign out_result = prod_q[L];
  assign unused_op  = ^op_q[L];
`endif

  // Shift valid, op and product through the stages on advance
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        vld_q[i]  <= 1'b0;
        op_q[i]   <= '0;
        prod_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      op_q[0]   <= in_valid ? in_op : 2'b00;
      prod_q[0] <= in_valid ? prod_in : '0;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        op_q[i]   <= op_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

endmodule
